// File: rtl/gemm_pkg.sv
// Shared widths, tile byte sizes and sequencer state encoding for the GEMM tile sequencer.
package gemm_pkg;
  localparam int ADDR_W    = 32;
  localparam int DIM_W     = 8;
  localparam int TILE_AB_W = 512;
  localparam int TILE_C_W  = 2048;

  localparam logic [ADDR_W-1:0] AB_TILE_BYTES = 32'd64;
  localparam logic [ADDR_W-1:0] C_TILE_BYTES  = 32'd256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;
endpackage

// File: rtl/gemm_c_fifo.sv
// Two-entry result buffer between the Gemm datapath and the C write port.
module gemm_c_fifo #(
  parameter int W = 2048
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         full_o,
  output logic [W-1:0] rdata_o
);
  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'd2);
  assign valid_o = (count_q != 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // A result arriving while both entries are occupied is dropped.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks the m/n/k tile loops of one GEMM command, issuing A/B tile reads and C tile writes.
module gemm_tile_sequencer
  import gemm_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DIM_W-1:0]     cmd_M,
  input  logic [DIM_W-1:0]     cmd_K,
  input  logic [DIM_W-1:0]     cmd_N,
  input  logic [ADDR_W-1:0]    cmd_ptr_a,
  input  logic [ADDR_W-1:0]    cmd_ptr_b,
  input  logic [ADDR_W-1:0]    cmd_ptr_c,
  input  logic [ADDR_W-1:0]    cmd_ld_a,
  input  logic [ADDR_W-1:0]    cmd_ld_b,
  input  logic [ADDR_W-1:0]    cmd_ld_c,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [ADDR_W-1:0]    rd_addr_a,
  output logic [ADDR_W-1:0]    rd_addr_b,
  input  logic                 rd_rsp_valid,
  input  logic [TILE_AB_W-1:0] rd_data_a,
  input  logic [TILE_AB_W-1:0] rd_data_b,
  output logic                 gemm_start_do,
  output logic                 gemm_data_in_valid,
  output logic [TILE_AB_W-1:0] gemm_a,
  output logic [TILE_AB_W-1:0] gemm_b,
  output logic [DIM_W-1:0]     gemm_M,
  output logic [DIM_W-1:0]     gemm_K,
  output logic [DIM_W-1:0]     gemm_N,
  input  logic                 gemm_data_out_valid,
  input  logic [TILE_C_W-1:0]  gemm_c,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [TILE_C_W-1:0]  wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          tile_count
);
  state_e state_q, state_d;

  logic [DIM_W-1:0]  dim_m_q, dim_k_q, dim_n_q;
  logic [DIM_W-1:0]  mi_q, ni_q, ki_q, nc_q;
  logic [ADDR_W-1:0] ptr_b_q, ld_a_q, ld_b_q, ld_c_q;
  logic [ADDR_W-1:0] row_a_q, row_b_q, row_c_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q, wr_addr_q;
  logic [1:0]        inflight_q;
  logic [15:0]       rsp_pend_q, tile_count_q;
  logic              ignore_q;

  logic accept, rd_fire, wr_fire, fwd;
  logic k_last, n_last, m_last, last_rd, tile_inc;

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign accept       = cmd_valid && cmd_ready;
  // A new (m,n) tile may not start while two result tiles are still unwritten.
  assign rd_req_valid = (state_q == S_RUN) && !((ki_q == '0) && (inflight_q == 2'd2));
  assign rd_fire      = rd_req_valid && rd_req_ready;
  assign k_last       = (ki_q == dim_k_q - DIM_W'(1));
  assign n_last       = (ni_q == dim_n_q - DIM_W'(1));
  assign m_last       = (mi_q == dim_m_q - DIM_W'(1));
  assign tile_inc     = rd_fire && k_last;
  assign last_rd      = tile_inc && n_last && m_last;
  assign wr_fire      = wr_valid && wr_ready;

  // Responses still in flight from an aborted command stay hidden until the bus goes quiet.
  assign fwd                = rd_rsp_valid && !ignore_q;
  assign gemm_data_in_valid = fwd;
  assign gemm_a             = fwd ? rd_data_a : '0;
  assign gemm_b             = fwd ? rd_data_b : '0;

  assign rd_addr_a  = addr_a_q;
  assign rd_addr_b  = addr_b_q;
  assign gemm_M     = dim_m_q;
  assign gemm_K     = dim_k_q;
  assign gemm_N     = dim_n_q;
  assign wr_addr    = wr_addr_q;
  assign tile_count = tile_count_q;

  gemm_c_fifo #(.W(TILE_C_W)) u_c_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (gemm_data_out_valid),
    .wdata_i (gemm_c),
    .pop_i   (wr_ready),
    .valid_o (wr_valid),
    .full_o  (),
    .rdata_o (wr_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    gemm_start_do = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ((cmd_M == '0) || (cmd_K == '0) || (cmd_N == '0)) state_d = S_DONE;
          else                                                  state_d = S_START;
        end
      end
      S_START: begin
        gemm_start_do = 1'b1;
        state_d       = S_RUN;
      end
      S_RUN:   if (last_rd) state_d = S_DRAIN;
      S_DRAIN: if ((inflight_q == 2'd0) && (rsp_pend_q == '0)) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      {dim_m_q, dim_k_q, dim_n_q}   <= '0;
      {mi_q, ni_q, ki_q, nc_q}      <= '0;
      {ptr_b_q, ld_a_q, ld_b_q, ld_c_q} <= '0;
      {row_a_q, row_b_q, row_c_q}   <= '0;
      {addr_a_q, addr_b_q, wr_addr_q} <= '0;
      inflight_q   <= 2'd0;
      rsp_pend_q   <= '0;
      tile_count_q <= '0;
      ignore_q     <= 1'b1;
    end else begin
      if (ignore_q && !rd_rsp_valid) ignore_q <= 1'b0;
      if (accept) begin
        dim_m_q      <= cmd_M;
        dim_k_q      <= cmd_K;
        dim_n_q      <= cmd_N;
        ptr_b_q      <= cmd_ptr_b;
        ld_a_q       <= cmd_ld_a;
        ld_b_q       <= cmd_ld_b;
        ld_c_q       <= cmd_ld_c;
        row_a_q      <= cmd_ptr_a;
        addr_a_q     <= cmd_ptr_a;
        row_b_q      <= cmd_ptr_b;
        addr_b_q     <= cmd_ptr_b;
        row_c_q      <= cmd_ptr_c;
        wr_addr_q    <= cmd_ptr_c;
        {mi_q, ni_q, ki_q, nc_q} <= '0;
        tile_count_q <= '0;
      end
      // Row bases advance by stride; k offsets step by one tile on top of the base.
      if (rd_fire) begin
        if (k_last) begin
          ki_q <= '0;
          if (n_last) begin
            ni_q     <= '0;
            mi_q     <= mi_q + DIM_W'(1);
            row_a_q  <= row_a_q + ld_a_q;
            addr_a_q <= row_a_q + ld_a_q;
            row_b_q  <= ptr_b_q;
            addr_b_q <= ptr_b_q;
          end else begin
            ni_q     <= ni_q + DIM_W'(1);
            addr_a_q <= row_a_q;
            row_b_q  <= row_b_q + ld_b_q;
            addr_b_q <= row_b_q + ld_b_q;
          end
        end else begin
          ki_q     <= ki_q + DIM_W'(1);
          addr_a_q <= addr_a_q + AB_TILE_BYTES;
          addr_b_q <= addr_b_q + AB_TILE_BYTES;
        end
      end
      inflight_q <= inflight_q + {1'b0, tile_inc} - {1'b0, wr_fire};
      rsp_pend_q <= rsp_pend_q + {15'd0, rd_fire} - {15'd0, fwd};
      if (wr_fire) begin
        if (tile_count_q != 16'hFFFF) tile_count_q <= tile_count_q + 16'd1;
        if (nc_q == dim_n_q - DIM_W'(1)) begin
          nc_q      <= '0;
          row_c_q   <= row_c_q + ld_c_q;
          wr_addr_q <= row_c_q + ld_c_q;
        end else begin
          nc_q      <= nc_q + DIM_W'(1);
          wr_addr_q <= wr_addr_q + C_TILE_BYTES;
        end
      end
    end
  end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench: expected reads/writes are queued at command issue and checked by bus monitors.
module tb_gemm_tile_sequencer;
  import gemm_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_M = '0, cmd_K = '0, cmd_N = '0;
  logic [31:0]   cmd_ptr_a = '0, cmd_ptr_b = '0, cmd_ptr_c = '0;
  logic [31:0]   cmd_ld_a = '0, cmd_ld_b = '0, cmd_ld_c = '0;
  logic          rd_req_valid;
  logic          rd_req_ready = 1'b0;
  logic [31:0]   rd_addr_a, rd_addr_b;
  logic          rd_rsp_valid = 1'b0;
  logic [511:0]  rd_data_a = '0, rd_data_b = '0;
  logic          gemm_start_do, gemm_data_in_valid;
  logic [511:0]  gemm_a, gemm_b;
  logic [7:0]    gemm_M, gemm_K, gemm_N;
  logic          gemm_data_out_valid = 1'b0;
  logic [2047:0] gemm_c = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [31:0]   wr_addr;
  logic [2047:0] wr_data;
  logic          busy, done;
  logic [15:0]   tile_count;

  gemm_tile_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_M(cmd_M), .cmd_K(cmd_K), .cmd_N(cmd_N),
    .cmd_ptr_a(cmd_ptr_a), .cmd_ptr_b(cmd_ptr_b), .cmd_ptr_c(cmd_ptr_c),
    .cmd_ld_a(cmd_ld_a), .cmd_ld_b(cmd_ld_b), .cmd_ld_c(cmd_ld_c),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_rsp_valid(rd_rsp_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .gemm_start_do(gemm_start_do), .gemm_data_in_valid(gemm_data_in_valid),
    .gemm_a(gemm_a), .gemm_b(gemm_b),
    .gemm_M(gemm_M), .gemm_K(gemm_K), .gemm_N(gemm_N),
    .gemm_data_out_valid(gemm_data_out_valid), .gemm_c(gemm_c),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .tile_count(tile_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [31:0]   exp_rd_a[$], exp_rd_b[$], exp_wr_addr[$];
  logic [2047:0] exp_wr_data[$];
  logic [31:0]   rsp_q_a[$], rsp_q_b[$];
  logic [2047:0] gres_q[$];
  int            gdue_q[$];

  bit rd_rand = 0, wr_rand = 0, wr_hold = 0, force_rsp = 0;
  int cur_k = 0;
  int rd_cnt = 0, wr_cnt = 0, start_cnt = 0, done_cnt = 0, cyc_no = 0;

  int           beat = 0;
  logic [511:0] acc_a = '0, acc_b = '0;
  bit           prev_stall = 0;
  logic [31:0]  prev_a = '0, prev_b = '0, ta, tb_a;

  // Read memory, response channel and Gemm datapath model.
  always @(negedge clock) begin
    cyc_no++;
    if (reset) begin
      rsp_q_a.delete(); rsp_q_b.delete(); gres_q.delete(); gdue_q.delete();
      beat = 0; acc_a = '0; acc_b = '0; prev_stall = 0;
      rd_rsp_valid = force_rsp; rd_data_a = '0; rd_data_b = '0;
      rd_req_ready = 1'b0; gemm_data_out_valid = 1'b0;
    end else if (force_rsp) begin
      rd_rsp_valid = 1'b1; rd_data_a = {16{32'hDEADBEEF}}; rd_data_b = {16{32'hCAFEF00D}};
      rd_req_ready = 1'b0; gemm_data_out_valid = 1'b0;
    end else begin
      if (rsp_q_a.size() > 0 && $urandom_range(0, 1) == 1) begin
        ta = rsp_q_a.pop_front(); tb_a = rsp_q_b.pop_front();
        rd_rsp_valid = 1'b1; rd_data_a = {16{ta}}; rd_data_b = {16{tb_a}};
        acc_a ^= rd_data_a; acc_b ^= rd_data_b; beat++;
        if (beat == cur_k) begin
          gres_q.push_back({acc_b, acc_a, acc_b, acc_a});
          gdue_q.push_back(cyc_no + int'($urandom_range(1, 4)));
          beat = 0; acc_a = '0; acc_b = '0;
        end
      end else begin
        rd_rsp_valid = 1'b0; rd_data_a = '0; rd_data_b = '0;
      end
      if (gdue_q.size() > 0 && gdue_q[0] <= cyc_no) begin
        gemm_data_out_valid = 1'b1; gemm_c = gres_q.pop_front(); void'(gdue_q.pop_front());
      end else begin
        gemm_data_out_valid = 1'b0;
      end
      if (prev_stall) begin
        chk("rd_hold_valid", 64'(rd_req_valid), 64'd1);
        chk("rd_hold_addr_a", 64'(rd_addr_a), 64'(prev_a));
        chk("rd_hold_addr_b", 64'(rd_addr_b), 64'(prev_b));
      end
      prev_stall = 0;
      rd_req_ready = rd_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rd_req_valid && rd_req_ready) begin
        rd_cnt++;
        chk("rd_exp_avail", 64'(exp_rd_a.size() != 0), 64'd1);
        if (exp_rd_a.size() != 0) begin
          chk("rd_addr_a", 64'(rd_addr_a), 64'(exp_rd_a.pop_front()));
          chk("rd_addr_b", 64'(rd_addr_b), 64'(exp_rd_b.pop_front()));
        end
        rsp_q_a.push_back(rd_addr_a); rsp_q_b.push_back(rd_addr_b);
      end else if (rd_req_valid) begin
        prev_stall = 1; prev_a = rd_addr_a; prev_b = rd_addr_b;
      end
      #1;
      chk("fwd_valid", 64'(gemm_data_in_valid), 64'(rd_rsp_valid));
      if (rd_rsp_valid)
        chk("fwd_data", 64'((gemm_a == rd_data_a) && (gemm_b == rd_data_b)), 64'd1);
    end
  end

  // C write sink.
  always @(negedge clock) begin
    if (reset) begin
      wr_ready = 1'b0;
    end else begin
      wr_ready = wr_hold ? 1'b0 : (wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (wr_valid && wr_ready) begin
        wr_cnt++;
        chk("wr_exp_avail", 64'(exp_wr_addr.size() != 0), 64'd1);
        if (exp_wr_addr.size() != 0) begin
          chk("wr_addr", 64'(wr_addr), 64'(exp_wr_addr.pop_front()));
          chk("wr_data", 64'(wr_data == exp_wr_data.pop_front()), 64'd1);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (gemm_start_do) start_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic push_exp(input int mm, kk, nn, input logic [31:0] pa, pb, pc, la, lb, lc);
    logic [31:0]  a, b;
    logic [511:0] xa, xb;
    if (mm * kk * nn == 0) return;
    for (int m = 0; m < mm; m++) begin
      for (int n = 0; n < nn; n++) begin
        xa = '0; xb = '0;
        for (int k = 0; k < kk; k++) begin
          a = pa + 32'(m) * la + 32'(k * 64);
          b = pb + 32'(n) * lb + 32'(k * 64);
          exp_rd_a.push_back(a); exp_rd_b.push_back(b);
          xa ^= {16{a}}; xb ^= {16{b}};
        end
        exp_wr_addr.push_back(pc + 32'(m) * lc + 32'(n * 256));
        exp_wr_data.push_back({xb, xa, xb, xa});
      end
    end
  endtask

  task automatic drive_cmd(input int mm, kk, nn, input logic [31:0] pa, pb, pc, la, lb, lc);
    cur_k = kk;
    cmd_M = 8'(mm); cmd_K = 8'(kk); cmd_N = 8'(nn);
    cmd_ptr_a = pa; cmd_ptr_b = pb; cmd_ptr_c = pc;
    cmd_ld_a = la; cmd_ld_b = lb; cmd_ld_c = lc;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_cmd(input int mm, kk, nn, input logic [31:0] pa, pb, pc, la, lb, lc,
                         input bit stall);
    int rd0, wr0, st0, dn0, cyc;
    bit seen, nz;
    nz = (mm * kk * nn != 0);
    push_exp(mm, kk, nn, pa, pb, pc, la, lb, lc);
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = start_cnt; dn0 = done_cnt;
    wr_hold = stall;
    drive_cmd(mm, kk, nn, pa, pb, pc, la, lb, lc);
    cyc = 0; seen = 0;
    while (!seen && cyc < 5000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("start_pulse", 64'(gemm_start_do), 64'(nz));
        chk("gemm_K", 64'(gemm_K), 64'(kk));
      end
      if (stall && cyc == 200) begin
        chk("stall_reads", 64'(rd_cnt - rd0), 64'd2);
        chk("stall_writes", 64'(wr_cnt - wr0), 64'd0);
        wr_hold = 0;
      end
      if (done) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (!nz) chk("done_latency", 64'(cyc), 64'd1);
    chk("tile_count", 64'(tile_count), 64'(nz ? mm * nn : 0));
    @(negedge clock);
    @(negedge clock);
    chk("rd_count", 64'(rd_cnt - rd0), 64'(mm * kk * nn));
    chk("wr_count", 64'(wr_cnt - wr0), 64'(nz ? mm * nn : 0));
    chk("start_count", 64'(start_cnt - st0), 64'(nz));
    chk("done_count", 64'(done_cnt - dn0), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("exp_rd_left", 64'(exp_rd_a.size()), 64'd0);
    chk("exp_wr_left", 64'(exp_wr_addr.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_start", 64'(gemm_start_do), 64'd0);
    chk("rst_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_in_valid", 64'(gemm_data_in_valid), 64'd0);
    chk("rst_tile_count", 64'(tile_count), 64'd0);
    chk("rst_gemm_mkn", 64'({gemm_M, gemm_K, gemm_N}), 64'd0);
    chk("rst_rd_addr", 64'({rd_addr_a, rd_addr_b}), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data == '0), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_reset_outputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_cmd(1, 1, 1, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h400, 0);
    run_cmd(2, 3, 2, 32'h0, 32'h8000, 32'h10000, 32'h100, 32'h100, 32'h400, 0);
    run_cmd(1, 1, 4, 32'h4000, 32'h5000, 32'h6000, 32'h100, 32'h100, 32'h400, 1);
    run_cmd(2, 0, 3, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h400, 0);
    rd_rand = 1;
    run_cmd(1, 2, 1, 32'hFFFFFFC0, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h400, 0);
    wr_rand = 1;
    for (int t = 0; t < 6; t++)
      run_cmd(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              $urandom & 32'hFFFF_FFC0, $urandom & 32'hFFFF_FFC0, $urandom & 32'hFFFF_FF00,
              $urandom & 32'h0000_FFC0, $urandom & 32'h0000_FFC0, $urandom & 32'h0000_FF00, 0);

    push_exp(3, 3, 3, 32'h100000, 32'h200000, 32'h300000, 32'h1000, 32'h1000, 32'h1000);
    drive_cmd(3, 3, 3, 32'h100000, 32'h200000, 32'h300000, 32'h1000, 32'h1000, 32'h1000);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (15) @(negedge clock);
    chk("busy_before_abort", 64'(busy), 64'd1);
    reset = 1'b1;
    force_rsp = 1;
    @(posedge clock);
    #1;
    chk_reset_outputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_rd_a.delete(); exp_rd_b.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
    #1;
    chk("stale_rsp_hidden", 64'(gemm_data_in_valid), 64'd0);
    @(posedge clock);
    #1;
    chk("stale_rsp_hidden2", 64'(gemm_data_in_valid), 64'd0);
    @(negedge clock);
    force_rsp = 0;
    repeat (3) @(negedge clock);
    run_cmd(2, 2, 2, 32'h7000, 32'h9000, 32'hA000, 32'h200, 32'h200, 32'h800, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
